axi_slave: RTL and testbench
============================

AXI_SLAVE -- requirements
Module: axi_slave

Interface
REQ-001 clock  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-low reset.
REQ-003 s_axi_awaddr  input  32  write address.
REQ-004 s_axi_awvalid  input  1  write address valid.
REQ-005 s_axi_awready  output  1  write address accept.
REQ-006 s_axi_wdata  input  32  write data.
REQ-007 s_axi_wstrb  input  4  write byte strobes.
REQ-008 s_axi_wvalid  input  1  write data valid.
REQ-009 s_axi_wready  output  1  write data accept.
REQ-010 s_axi_bresp  output  2  write response, always 2'b00 (OKAY).
REQ-011 s_axi_bvalid  output  1  write response valid.
REQ-012 s_axi_bready  input  1  write response accept.
REQ-013 s_axi_araddr  input  32  read address.
REQ-014 s_axi_arprot  input  3  read protection; bit 2 marks an instruction fetch.
REQ-015 s_axi_arvalid  input  1  read address valid.
REQ-016 s_axi_arready  output  1  read address accept.
REQ-017 s_axi_rdata  output  32  read data.
REQ-018 s_axi_rresp  output  2  read response, always 2'b00.
REQ-019 s_axi_rlast  output  1  last beat; equals s_axi_rvalid.
REQ-020 s_axi_rvalid  output  1  read data valid.
REQ-021 s_axi_rready  input  1  read data accept.
REQ-022 mem_valid  output  1  one-cycle request pulse to memory.
REQ-023 mem_instr  output  1  request is an instruction fetch.
REQ-024 mem_addr  output  32  word-aligned address, held until mem_ready.
REQ-025 mem_wdata  output  32  store data, held until mem_ready.
REQ-026 mem_wstrb  output  4  byte strobes; 0 means load.
REQ-027 mem_rdata  input  32  load data, valid with mem_ready.
REQ-028 mem_ready  input  1  request complete (one-cycle pulse).

Function
REQ-029 The block SHALL be single-beat only: no burst, length, size or cache fields; one outstanding transaction.
REQ-030 The FSM SHALL have the states IDLE, WRITE, READ, BRESP and RRESP.
REQ-031 In IDLE: awready = ~aw_held; wready = ~w_held; arready = ~aw_held & ~w_held & ~awvalid & ~wvalid. Ready is 0 in every other state.
REQ-032 AW and W handshakes SHALL be latched independently in any order. When both are held (including when both complete in the same cycle), the FSM SHALL go to WRITE.
REQ-033 A write SHALL win over a read: a read is accepted only when no write-channel valid or held half is present.
REQ-034 On entry to WRITE: mem_valid=1 for exactly one cycle, with mem_addr={awaddr[31:2],2'b00}, mem_wdata=wdata, mem_wstrb=wstrb and mem_instr=0.
REQ-035 On an AR handshake the FSM SHALL go to READ. The next cycle drives mem_valid=1 for one cycle, with mem_addr={araddr[31:2],2'b00}, mem_wstrb=0 and mem_instr=arprot[2].
REQ-036 mem_addr, mem_wdata, mem_wstrb and mem_instr SHALL stay stable from the mem_valid cycle until the mem_ready cycle.
REQ-037 A write with wstrb=4'b0000 SHALL still be forwarded to memory as-is and SHALL complete with a B response.
REQ-038 mem_ready in WRITE at cycle M SHALL give bvalid=1 and bresp=00 at M+1, and the FSM goes to BRESP.
REQ-039 mem_ready in READ at cycle M SHALL give rvalid=1, rlast=1, rresp=00 and rdata=mem_rdata (as sampled at M) at M+1, and the FSM goes to RRESP.
REQ-040 bvalid and rvalid, with their data, SHALL hold until bready or rready is seen. That cycle clears the held flags and returns the FSM to IDLE; the next handshake is accepted no earlier than the following cycle.
REQ-041 mem_ready SHALL be ignored in IDLE, BRESP and RRESP.
REQ-042 Minimum latency: handshake cycle N gives mem_valid at N+1; a response is never issued in the same cycle as mem_ready.

Reset
REQ-043 While reset=0, every output SHALL be 0, the FSM SHALL be IDLE, and the held flags SHALL be cleared.
REQ-044 A reset during any state SHALL drop the pending transaction with no response. Normal handshakes SHALL be accepted from the first cycle after reset=1.

Verification
REQ-045 Read: araddr=0x00001006, arprot=3'b100, arvalid=1 -> arready=1 in the same cycle. Next cycle: mem_valid=1, mem_addr=0x00001004, mem_instr=1, mem_wstrb=0. mem_ready with mem_rdata=0xDEADBEEF three cycles later -> next cycle rvalid=1, rdata=0xDEADBEEF, rlast=1, rresp=00.
REQ-046 Write with split channels: awaddr=0x2000 accepted, then wdata=0x12345678 with wstrb=4'b0011 two cycles later. -> mem_valid appears only the cycle after the W handshake, with matching addr, data and strobes. After mem_ready, bvalid=1 holds for 3 cycles of bready=0, then clears the cycle after bready=1.
REQ-047 awvalid, wvalid and arvalid all asserted in IDLE -> arready=0, the write is performed first, and the read is accepted only after the B handshake completes.
REQ-048 R backpressure: rready=0 for 4 cycles with stray mem_ready pulses -> rvalid and rdata stay stable, and there is no extra mem_valid.
REQ-049 reset=0 during WRITE before mem_ready -> all outputs 0 on the next cycle, and no bvalid ever appears for that write. A following read completes normally.

Source files
------------

// File: rtl/axi_slave.sv
// ---------------------------------------------------------------------------
// axi_slave
//   Single-beat AXI-lite style slave that forwards each accepted transaction
//   to a simple valid/ready memory port. Only one transaction is ever in
//   flight; a write (AW + W, in any order) always beats a pending read.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-low reset
//   s_axi_aw*/w*/b*         write address / data / response channels
//   s_axi_ar*/r*            read address / data channels (arprot[2] = fetch)
//   mem_valid               one-cycle request pulse to memory
//   mem_instr               request is an instruction fetch
//   mem_addr/wdata/wstrb    request fields, held until mem_ready
//   mem_rdata, mem_ready    memory completion (ready is a one-cycle pulse)
// ---------------------------------------------------------------------------
module axi_slave (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] s_axi_awaddr,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic [2:0]  s_axi_arprot,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_BRESP,
      S_RRESP
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic        r_aw_held;
   logic        r_w_held;
   logic        r_mem_valid;
   logic        r_instr;
   logic        r_bvalid;
   logic        r_rvalid;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [3:0]  r_wstrb;

   logic        w_awready;
   logic        w_wready;
   logic        w_arready;
   logic        w_aw_hs;
   logic        w_w_hs;
   logic        w_ar_hs;

   // Address LSBs are dropped (word-aligned requests) and only the fetch
   // bit of arprot is meaningful here.
   logic        w_unused;
   assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_arprot[1:0]};

   // State register
   always_ff @(posedge clock) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state and channel readies
   always_comb begin
      w_next    = r_state;
      w_awready = 1'b0;
      w_wready  = 1'b0;
      w_arready = 1'b0;
      w_aw_hs   = 1'b0;
      w_w_hs    = 1'b0;
      w_ar_hs   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_awready = ~r_aw_held;
            w_wready  = ~r_w_held;
            // Any sign of a write (held or presented) blocks the read.
            w_arready = ~r_aw_held & ~r_w_held & ~s_axi_awvalid & ~s_axi_wvalid;
            w_aw_hs   = s_axi_awvalid & w_awready;
            w_w_hs    = s_axi_wvalid  & w_wready;
            w_ar_hs   = s_axi_arvalid & w_arready;
            if ((r_aw_held | w_aw_hs) & (r_w_held | w_w_hs)) w_next = S_WRITE;
            else if (w_ar_hs)                                w_next = S_READ;
         end
         S_WRITE: if (mem_ready)    w_next = S_BRESP;
         S_READ:  if (mem_ready)    w_next = S_RRESP;
         S_BRESP: if (s_axi_bready) w_next = S_IDLE;
         S_RRESP: if (s_axi_rready) w_next = S_IDLE;
         default:                   w_next = S_IDLE;
      endcase
   end

   // Datapath: request fields are only written in IDLE, so they stay
   // stable for the whole memory access.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_aw_held   <= 1'b0;
         r_w_held    <= 1'b0;
         r_mem_valid <= 1'b0;
         r_instr     <= 1'b0;
         r_bvalid    <= 1'b0;
         r_rvalid    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_wstrb     <= '0;
      end else begin
         r_mem_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_aw_hs) begin
                  r_addr    <= {s_axi_awaddr[31:2], 2'b00};
                  r_aw_held <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wdata  <= s_axi_wdata;
                  r_wstrb  <= s_axi_wstrb;
                  r_w_held <= 1'b1;
               end
               if (w_next == S_WRITE) begin
                  r_mem_valid <= 1'b1;
                  r_instr     <= 1'b0;
               end
               if (w_ar_hs) begin
                  r_addr      <= {s_axi_araddr[31:2], 2'b00};
                  r_wstrb     <= 4'b0000;
                  r_instr     <= s_axi_arprot[2];
                  r_mem_valid <= 1'b1;
               end
            end
            S_WRITE: if (mem_ready) r_bvalid <= 1'b1;
            S_READ: begin
               if (mem_ready) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= mem_rdata;
               end
            end
            S_BRESP: begin
               if (s_axi_bready) begin
                  r_bvalid  <= 1'b0;
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
               end
            end
            S_RRESP: if (s_axi_rready) r_rvalid <= 1'b0;
            default: ;
         endcase
      end
   end

   // Outputs are forced low for as long as reset is asserted, not only
   // after the first clock edge inside reset.
   assign s_axi_awready = reset & w_awready;
   assign s_axi_wready  = reset & w_wready;
   assign s_axi_arready = reset & w_arready;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_bvalid  = reset & r_bvalid;
   assign s_axi_rresp   = 2'b00;
   assign s_axi_rvalid  = reset & r_rvalid;
   assign s_axi_rlast   = reset & r_rvalid;
   assign s_axi_rdata   = reset ? r_rdata : 32'h0;
   assign mem_valid     = reset & r_mem_valid;
   assign mem_instr     = reset & r_instr;
   assign mem_addr      = reset ? r_addr  : 32'h0;
   assign mem_wdata     = reset ? r_wdata : 32'h0;
   assign mem_wstrb     = reset ? r_wstrb : 4'h0;

endmodule

// File: tb/tb_axi_slave.sv
module tb_axi_slave;

   logic        clock;
   logic        reset;
   logic [31:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [31:0] s_axi_araddr;
   logic [2:0]  s_axi_arprot;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rlast;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   axi_slave dut (
      .clock(clock), .reset(reset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata),
      .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready), .mem_valid(mem_valid), .mem_instr(mem_instr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        instr;
      logic        is_wr;
   } mem_exp_t;

   typedef struct {
      logic        is_wr;
      logic [31:0] data;
   } rsp_exp_t;

   mem_exp_t mq[$];
   rsp_exp_t rq[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      logic [111:0] outs;
      outs = {s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready,
              s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid, mem_valid, mem_instr,
              mem_addr, mem_wdata, mem_wstrb};
      total++;
      if (outs !== '0) begin
         bad++;
         $display("FAIL %s actual=%h required=0", nm, outs);
      end
   endtask

   task automatic push_mem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic ins, input logic wr);
      mem_exp_t e;
      e.addr = a; e.wdata = d; e.strb = s; e.instr = ins; e.is_wr = wr;
      mq.push_back(e);
   endtask

   task automatic push_rsp(input logic wr, input logic [31:0] d);
      rsp_exp_t e;
      e.is_wr = wr; e.data = d;
      rq.push_back(e);
   endtask

   // Monitor: every memory request and every completed B/R handshake is
   // matched against the oldest expectation.
   always @(negedge clock) begin
      mem_exp_t me;
      rsp_exp_t re;
      if (mem_valid) begin
         if (mq.size() == 0) chk("mem_valid unexpected", {31'b0, mem_valid}, 32'd0);
         else begin
            me = mq.pop_front();
            chk("mem_addr", mem_addr, me.addr);
            chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, me.strb});
            chk("mem_instr", {31'b0, mem_instr}, {31'b0, me.instr});
            if (me.is_wr) chk("mem_wdata", mem_wdata, me.wdata);
         end
      end
      if (s_axi_bvalid && s_axi_bready) begin
         if (rq.size() == 0) chk("bvalid unexpected", {31'b0, s_axi_bvalid}, 32'd0);
         else begin
            re = rq.pop_front();
            chk("b where expected", {31'b0, s_axi_bvalid}, {31'b0, re.is_wr});
            chk("bresp", {30'b0, s_axi_bresp}, 32'd0);
         end
      end
      if (s_axi_rvalid && s_axi_rready) begin
         if (rq.size() == 0) chk("rvalid unexpected", {31'b0, s_axi_rvalid}, 32'd0);
         else begin
            re = rq.pop_front();
            chk("r where expected", {31'b0, s_axi_rvalid}, {31'b0, ~re.is_wr});
            chk("rdata", s_axi_rdata, re.data);
            chk("rlast", {31'b0, s_axi_rlast}, 32'd1);
            chk("rresp", {30'b0, s_axi_rresp}, 32'd0);
         end
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic ar_req(input logic [31:0] a, input logic [2:0] p);
      int n;
      s_axi_araddr = a; s_axi_arprot = p; s_axi_arvalid = 1'b1;
      #1;
      n = 0;
      while (!s_axi_arready && n < 20) begin tick; n++; end
      chk("arready seen", {31'b0, s_axi_arready}, 32'd1);
      tick;
      s_axi_arvalid = 1'b0;
   endtask

   task automatic wr_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      #1;
      chk("awready both", {31'b0, s_axi_awready}, 32'd1);
      chk("wready both", {31'b0, s_axi_wready}, 32'd1);
      tick;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
   endtask

   task automatic mem_resp(input int dly, input logic [31:0] d);
      int n;
      n = 0;
      while (!mem_valid && n < 20) begin tick; n++; end
      chk("mem_valid seen", {31'b0, mem_valid}, 32'd1);
      repeat (dly) tick;
      mem_ready = 1'b1; mem_rdata = d;
      tick;
      mem_ready = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic rsp_accept(input logic wr, input int stall);
      for (int i = 0; i < stall; i++) begin
         chk(wr ? "bvalid held" : "rvalid held",
             {31'b0, (wr ? s_axi_bvalid : s_axi_rvalid)}, 32'd1);
         tick;
      end
      if (wr) s_axi_bready = 1'b1; else s_axi_rready = 1'b1;
      tick;
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      chk(wr ? "bvalid cleared" : "rvalid cleared",
          {31'b0, (wr ? s_axi_bvalid : s_axi_rvalid)}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
      s_axi_bready = 0; s_axi_araddr = 0; s_axi_arprot = 0; s_axi_arvalid = 0; s_axi_rready = 0;
      mem_rdata = 0; mem_ready = 0;

      // reset state
      tick; tick;
      chk_zero("outputs in reset");
      reset = 1'b1;
      #1;
      chk("awready after reset", {31'b0, s_axi_awready}, 32'd1);
      chk("arready after reset", {31'b0, s_axi_arready}, 32'd1);

      // fetch read, unaligned address, memory answers three cycles later
      push_mem(32'h0000_1004, 32'h0, 4'h0, 1'b1, 1'b0);
      push_rsp(1'b0, 32'hDEAD_BEEF);
      ar_req(32'h0000_1006, 3'b100);
      mem_resp(3, 32'hDEAD_BEEF);
      chk("rvalid after mem_ready", {31'b0, s_axi_rvalid}, 32'd1);
      rsp_accept(1'b0, 0);

      // split AW then W, B held under backpressure
      s_axi_awaddr = 32'h0000_2000; s_axi_awvalid = 1'b1;
      #1;
      chk("awready split", {31'b0, s_axi_awready}, 32'd1);
      chk("arready blocked by awvalid", {31'b0, s_axi_arready}, 32'd0);
      tick;
      s_axi_awvalid = 1'b0;
      #1;
      chk("awready after aw held", {31'b0, s_axi_awready}, 32'd0);
      chk("arready blocked by aw held", {31'b0, s_axi_arready}, 32'd0);
      tick;
      chk("no mem_valid before W", {31'b0, mem_valid}, 32'd0);
      push_mem(32'h0000_2000, 32'h1234_5678, 4'b0011, 1'b0, 1'b1);
      push_rsp(1'b1, 32'h0);
      s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'b0011; s_axi_wvalid = 1'b1;
      #1;
      chk("wready split", {31'b0, s_axi_wready}, 32'd1);
      chk("mem_valid not in W hs cycle", {31'b0, mem_valid}, 32'd0);
      tick;
      s_axi_wvalid = 1'b0;
      chk("mem_valid after W hs", {31'b0, mem_valid}, 32'd1);
      tick;
      chk("mem_valid single cycle", {31'b0, mem_valid}, 32'd0);
      chk("mem_addr held", mem_addr, 32'h0000_2000);
      mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      chk("bvalid after mem_ready", {31'b0, s_axi_bvalid}, 32'd1);
      rsp_accept(1'b1, 3);

      // all three valids at once: write first, read after B
      s_axi_araddr = 32'h0000_4000; s_axi_arprot = 3'b000; s_axi_arvalid = 1'b1;
      push_mem(32'h0000_3008, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1);
      push_rsp(1'b1, 32'h0);
      push_mem(32'h0000_4000, 32'h0, 4'h0, 1'b0, 1'b0);
      push_rsp(1'b0, 32'h0BAD_CAFE);
      s_axi_awaddr = 32'h0000_300A; s_axi_wdata = 32'hCAFE_F00D; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      #1;
      chk("arready with write pending", {31'b0, s_axi_arready}, 32'd0);
      tick;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      chk("arready in WRITE", {31'b0, s_axi_arready}, 32'd0);
      mem_resp(1, 32'h0);
      chk("arready in BRESP", {31'b0, s_axi_arready}, 32'd0);
      rsp_accept(1'b1, 0);
      chk("arready after B", {31'b0, s_axi_arready}, 32'd1);
      tick;
      s_axi_arvalid = 1'b0;
      mem_resp(1, 32'h0BAD_CAFE);
      rsp_accept(1'b0, 0);

      // R backpressure with stray mem_ready pulses
      push_mem(32'h0000_5554, 32'h0, 4'h0, 1'b0, 1'b0);
      push_rsp(1'b0, 32'h1122_3344);
      ar_req(32'h0000_5557, 3'b001);
      mem_resp(2, 32'h1122_3344);
      for (int i = 0; i < 4; i++) begin
         chk("rdata stable", s_axi_rdata, 32'h1122_3344);
         chk("rvalid stable", {31'b0, s_axi_rvalid}, 32'd1);
         mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
         tick;
      end
      mem_ready = 1'b0; mem_rdata = 32'h0;
      rsp_accept(1'b0, 0);

      // zero-strobe write still goes to memory and completes
      push_mem(32'h0000_600C, 32'h55AA_55AA, 4'h0, 1'b0, 1'b1);
      push_rsp(1'b1, 32'h0);
      wr_both(32'h0000_600C, 32'h55AA_55AA, 4'h0);
      mem_resp(2, 32'h0);
      rsp_accept(1'b1, 1);

      // reset in WRITE drops the transaction
      push_mem(32'h0000_7000, 32'h0000_0001, 4'hF, 1'b0, 1'b1);
      wr_both(32'h0000_7000, 32'h0000_0001, 4'hF);
      tick;
      reset = 1'b0;
      #1;
      chk_zero("outputs as reset asserts");
      tick;
      chk_zero("outputs after reset edge");
      reset = 1'b1;
      s_axi_bready = 1'b1;
      mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("no bvalid after reset", {31'b0, s_axi_bvalid}, 32'd0);
         tick;
      end
      s_axi_bready = 1'b0;
      push_mem(32'h0000_8010, 32'h0, 4'h0, 1'b1, 1'b0);
      push_rsp(1'b0, 32'hA5A5_0F0F);
      ar_req(32'h0000_8010, 3'b100);
      mem_resp(1, 32'hA5A5_0F0F);
      rsp_accept(1'b0, 0);

      tick; tick;
      chk("mem queue drained", mq.size(), 32'd0);
      chk("rsp queue drained", rq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
